// File: rtl/fifo_sync_pkg.sv
// -----------------------------------------------------------------------------
// fifo_sync_pkg
// Shared constants and helpers for the parametrised single-clock FIFO.
//   - Default widths for bw, simd and depth_log2.
//   - ptr_w(): pointer width (address bits plus one wrap bit).
//   - *_ok(): configuration legality checks used at elaboration time.
// No ports (package).
// -----------------------------------------------------------------------------
package fifo_sync_pkg;

    localparam int BW_DEFAULT         = 32'sd4;
    localparam int SIMD_DEFAULT       = 32'sd1;
    localparam int DEPTH_LOG2_DEFAULT = 32'sd6;

    // Pointer width: one extra MSB distinguishes full from empty when addresses match.
    function automatic int ptr_w(input int depth_log2);
        return depth_log2 + 32'sd1;
    endfunction

    function automatic bit depth_ok(input int depth_log2);
        return (depth_log2 >= 32'sd1) && (depth_log2 <= 32'sd8);
    endfunction

    function automatic bit af_ok(input int depth_log2, input int af_level);
        return (af_level >= 32'sd1) && (af_level <= (32'sd1 << depth_log2));
    endfunction

    function automatic bit ae_ok(input int depth_log2, input int ae_level);
        return (ae_level >= 32'sd0) && (ae_level <= ((32'sd1 << depth_log2) - 32'sd1));
    endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// -----------------------------------------------------------------------------
// fifo_sync_mem
// 2**AW x DW register array: one synchronous write port and a combinational
// read mux. Contents are deliberately not reset.
// Ports:
//   clk_i    : clock, rising edge
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data (combinational from raddr_i)
// -----------------------------------------------------------------------------
module fifo_sync_mem
    import fifo_sync_pkg::*;
#(
    parameter int DW = BW_DEFAULT * SIMD_DEFAULT,
    parameter int AW = DEPTH_LOG2_DEFAULT
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(2**AW)-1];

    // Storage write port; no reset so the array maps onto plain flops/RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_param.sv
// -----------------------------------------------------------------------------
// fifo_sync_param
// Single-clock synchronous FIFO, first-word-fall-through, depth 2**depth_log2,
// data width simd*bw, with occupancy count and programmable almost flags.
// Writes are never allowed to overwrite when full unless a read is accepted in
// the same cycle. Optional sticky error flags when FIFO_SYNC_ERR_FLAG_EN is
// defined.
// Ports:
//   clk            : clock, rising edge
//   reset          : synchronous active-low reset
//   in             : write data
//   wr / rd        : push / pop requests
//   out            : head-of-queue data, 0 when empty
//   o_full/o_empty : count == depth / count == 0
//   o_almost_full  : count >= af_level
//   o_almost_empty : count <= ae_level
//   o_count        : occupancy 0..depth
//   o_overflow     : (FIFO_SYNC_ERR_FLAG_EN) sticky, push rejected
//   o_underflow    : (FIFO_SYNC_ERR_FLAG_EN) sticky, pop while empty
// -----------------------------------------------------------------------------
module fifo_sync_param
    import fifo_sync_pkg::*;
#(
    parameter int bw         = BW_DEFAULT,
    parameter int simd       = SIMD_DEFAULT,
    parameter int depth_log2 = DEPTH_LOG2_DEFAULT,
    parameter int af_level   = 32'sd60,
    parameter int ae_level   = 32'sd4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [simd*bw-1:0]     in,
    input  logic                   wr,
    input  logic                   rd,
    output logic [simd*bw-1:0]     out,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_almost_full,
    output logic                   o_almost_empty,
    output logic [depth_log2:0]    o_count
`ifdef FIFO_SYNC_ERR_FLAG_EN
    ,
    output logic                   o_overflow,
    output logic                   o_underflow
`endif
);

    localparam int DW = simd * bw;
    localparam int AW = depth_log2;
    localparam int PW = ptr_w(depth_log2);
    localparam logic [PW-1:0] PTR_INC = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] AF_LVL  = PW'(af_level);
    localparam logic [PW-1:0] AE_LVL  = PW'(ae_level);
    localparam bit CFG_OK = depth_ok(depth_log2) && af_ok(depth_log2, af_level)
                          && ae_ok(depth_log2, ae_level);

    generate
        if (!CFG_OK) begin : g_cfg_check
            $error("fifo_sync_param: illegal depth_log2/af_level/ae_level");
        end
    endgenerate

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_s;
    logic          empty_s;
    logic          full_s;
    logic          rd_acc_s;
    logic          wr_acc_s;
    logic [DW-1:0] mem_rdata_s;

    // Status derives only from registered pointers, so flags move after an edge.
    assign count_s = wr_ptr_q - rd_ptr_q;
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // Accept rules and next pointers; a read frees the slot a full-FIFO write needs.
    always_comb begin
        rd_acc_s = rd & ~empty_s;
        wr_acc_s = wr & (~full_s | rd_acc_s);
        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + PTR_INC;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + PTR_INC;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers; reset discards the queue and ignores same-cycle requests.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    fifo_sync_mem #(
        .DW (DW),
        .AW (AW)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_acc_s & reset),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (in),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (mem_rdata_s)
    );

    // Empty forces 0 so stale (or never-written) storage is never exposed.
    assign out            = empty_s ? {DW{1'b0}} : mem_rdata_s;
    assign o_full         = full_s;
    assign o_empty        = empty_s;
    assign o_count        = count_s;
    assign o_almost_full  = (count_s >= AF_LVL);
    assign o_almost_empty = (count_s <= AE_LVL);

`ifdef FIFO_SYNC_ERR_FLAG_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error accumulation.
    always_comb begin
        overflow_d  = overflow_q | (wr & ~wr_acc_s);
        underflow_d = underflow_q | (rd & empty_s);
    end

    // Error flag registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;
`endif

endmodule
